// File: rtl/bcd_seg_pkg.sv
// rtl/bcd_seg_pkg.sv - shared BCD type, segment patterns and decoder
package bcd_seg_pkg;

   typedef logic [3:0] bcd_t;

   // Common-anode segments, active-low, ordered {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   function automatic logic [6:0] bcd_to_seg(bcd_t d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_DIGIT[0];
         4'd1:    s = SEG_DIGIT[1];
         4'd2:    s = SEG_DIGIT[2];
         4'd3:    s = SEG_DIGIT[3];
         4'd4:    s = SEG_DIGIT[4];
         4'd5:    s = SEG_DIGIT[5];
         4'd6:    s = SEG_DIGIT[6];
         4'd7:    s = SEG_DIGIT[7];
         4'd8:    s = SEG_DIGIT[8];
         4'd9:    s = SEG_DIGIT[9];
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// rtl/bcd_seg_scan_if.sv - BCD input and multiplexed display bundle
interface bcd_seg_scan_if #(
   parameter int DIGITS = 4
);
   import bcd_seg_pkg::*;

   bcd_t              bcd_in;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;
   logic              wrap;

   modport master (output bcd_in, input seg, input an, input wrap);
   modport slave  (input bcd_in, output seg, output an, output wrap);

endinterface

// File: rtl/bcd_digit_cnt.sv
// rtl/bcd_digit_cnt.sv - one decimal stage of the wrap-count cascade
module bcd_digit_cnt
   import bcd_seg_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic inc,
   output bcd_t q,
   output logic carry
);

   assign carry = inc && (q == 4'd9);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (inc) begin
         q <= carry ? 4'd0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - BCD wrap-count extender and 7-seg scanner; option BCD_SEG_SCAN_LEADING_BLANK_EN
module bcd_seg_scan
   import bcd_seg_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic          clk,
   input  logic          rst,
   bcd_seg_scan_if.slave bus
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(DIGITS);

   bcd_t              bcd_q;
   logic              wrap_det;
   logic              wrap_r;
   logic [CNT_W-1:0]  refresh_cnt;
   logic [IDX_W-1:0]  idx;
   logic [6:0]        seg_r;
   logic [6:0]        seg_next;
   logic [DIGITS-1:0] an_r;
   logic [DIGITS-1:0] blank_mask;

   logic [DIGITS-1:1] stage_inc;
   logic [DIGITS-1:1] stage_carry;
   bcd_t              upper_q   [1:DIGITS-1];
   bcd_t              digit_val [0:DIGITS-1];
   logic              rollover_unused;

   // 9 and 0 are both valid codes, so invalid transitions can never match
   assign wrap_det = (bcd_q == 4'd9) && (bus.bcd_in == 4'd0);

   for (genvar k = 1; k < DIGITS; k++) begin : g_stage
      if (k == 1) begin : g_first
         assign stage_inc[k] = wrap_det;
      end else begin : g_next
         assign stage_inc[k] = stage_carry[k-1];
      end

      bcd_digit_cnt u_cnt (
         .clk   (clk),
         .rst   (rst),
         .inc   (stage_inc[k]),
         .q     (upper_q[k]),
         .carry (stage_carry[k])
      );
   end

   // All-9s rolls silently to all-0s
   assign rollover_unused = stage_carry[DIGITS-1];

   always_comb begin
      digit_val[0] = bcd_q;
      for (int k = 1; k < DIGITS; k++) begin
         digit_val[k] = upper_q[k];
      end
   end

`ifdef BCD_SEG_SCAN_LEADING_BLANK_EN
   // Blank an upper digit when it and every digit above it are zero
   always_comb begin
      logic all_zero;
      all_zero   = 1'b1;
      blank_mask = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         all_zero      = all_zero && (upper_q[k] == 4'd0);
         blank_mask[k] = all_zero;
      end
   end
`else
   assign blank_mask = '0;
`endif

   always_comb begin
      seg_next = bcd_to_seg(digit_val[idx]);
      if (blank_mask[idx]) begin
         seg_next = SEG_BLANK;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_q       <= '0;
         wrap_r      <= 1'b0;
         refresh_cnt <= '0;
         idx         <= '0;
         seg_r       <= SEG_BLANK;
         an_r        <= '1;
      end else begin
         bcd_q  <= bus.bcd_in;
         wrap_r <= wrap_det;
         seg_r  <= seg_next;
         an_r   <= ~(DIGITS'(1) << idx);
         if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            idx         <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
         end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
         end
      end
   end

   assign bus.seg  = seg_r;
   assign bus.an   = an_r;
   assign bus.wrap = wrap_r;

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Downstream display stage for the two-speed BCD counter. Samples the 4-bit BCD count each `clk`, extends it to a multi-digit decimal value by counting its 9→0 wraps, and drives a time-multiplexed, active-low common-anode 7-segment display. All logic runs on the single system clock; the counter's 4-bit output connects directly to `bcd_in`.

## Interface
- `DIGITS`, default 4: display digits; digit 0 shows the live input, digits 1..DIGITS-1 show the wrap count. Legal range 2..8.
- `REFRESH_DIV`, default 50000: `clk` cycles each digit is lit. Legal range ≥ 2.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `bcd_in`  input  4  BCD digit from the upstream counter.
- `seg`  output  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  output  DIGITS  digit enables, active-low, one-hot-low.
- `wrap`  output  1  one-cycle pulse on each detected 9→0 input wrap.

## Operation
- Input register: `bcd_q <= bcd_in` every cycle.
- Wrap detect: combinational `bcd_q == 9 && bcd_in == 0`. On that edge, `wrap` is registered high for exactly one cycle and the upper cascade increments.
- Upper cascade: DIGITS-1 BCD digits, digit 1 least significant. Each digit counts 0..9; on increment at 9 it returns to 0 and carries into the next digit. All-9s rolls over to all-0s with no saturation and no flag.
- Invalid input (`bcd_in` 10..15):
  - Digit 0 displays blank (`seg = 7'h7F`).
  - A transition into or out of an invalid code never counts as a wrap.
- Scan:
  - Refresh counter runs 0..REFRESH_DIV-1.
  - At terminal count, the digit index advances 0→1→…→DIGITS-1→0.
  - `an[idx]` is low and all other `an` bits are high.
- Decode:
  - 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000, 4 = 7'b0011001.
  - 5 = 7'b0010010, 6 = 7'b0000010, 7 = 7'b1111000, 8 = 7'b0000000, 9 = 7'b0010000.
- Only the upstream 9→0 sequence counts. A jump such as 9→3 does not count.

## Timing
- `rst` is evaluated at the rising edge. While `rst` is high, every register clears at that edge:
  - `bcd_q = 0`, cascade = 0, refresh counter = 0, index = 0.
  - `seg = 7'h7F`, `an = '1` (all off), `wrap = 0`.
- First cycle after `rst` deasserts:
  - `an` selects digit 0.
  - `seg` shows `bcd_q`, which is 0.
- Wrap is detected on edge N, when `bcd_q` = 9 and `bcd_in` = 0. `wrap` is high and the cascade is updated from edge N, valid in the following cycle.
- `seg`/`an` are registered:
  - They reflect the index and digit value from the previous cycle.
  - The digit 0 display lags `bcd_in` by 2 cycles.
- Reset mid-scan or mid-wrap: the reset overrides. No increment occurs on an edge where `rst` is high, even if a wrap condition is present.
- Upstream reset from 9 (9→0 with `rst` low here) counts as a wrap. This is the defined behaviour.

## Configuration
- `BCD_SEG_SCAN_LEADING_BLANK_EN` defined:
  - Upper digits that are zero and above the most significant nonzero upper digit display blank (`seg = 7'h7F`, anode still driven).
  - Digit 0 is never blanked by this rule.
- Not defined: all digits always display their value, including leading zeros.

## Structure
- Package `bcd_seg_pkg`:
  - `typedef logic [3:0] bcd_t`.
  - Segment constants `SEG_BLANK` and `SEG_DIGIT[0:9]`.
  - Function `bcd_to_seg(bcd_t)` returning blank for 10..15.
- Sub-module `bcd_digit_cnt`:
  - Ports: `clk`, `rst`, `inc`, `q[3:0]`, `carry`.
  - One cascade stage, instantiated DIGITS-1 times in a generate loop.
- Top level holds the input register, wrap detect, scan counter, and output registers.

## Test plan
- Reset: hold `rst` 3 cycles with `bcd_in` = 7. Then `seg` = 7'h7F, `an` = 4'b1111, `wrap` = 0. One cycle after release, `an` = 4'b1110 and `seg` = 7'b1000000.
- Single wrap (REFRESH_DIV = 4): drive `bcd_in` 8, 9, 0. `wrap` pulses one cycle. When digit 1 is scanned, `an` = 4'b1101 and `seg` = 7'b1111001.
- Cascade rollover: drive 999 wraps, then 1 more. Upper digits go from 9,9,9 to 0,0,0, with no extra `wrap` pulses.
- Invalid input: `bcd_in` = 9, 12, 0. Digit 0 displays 7'h7F while the value is 12. No wrap occurs and the cascade is unchanged.
- Reset mid-wrap: `bcd_q` = 9, `bcd_in` = 0, and `rst` high on the same edge. Cascade = 0 and `wrap` = 0.
- Leading blank, both builds, cascade = 0,0,5:
  - With the macro: digits 3..2 show 7'h7F and digit 1 shows 7'b0010010.
  - Without the macro: digits 3..2 show 7'b1000000.
